// File: rtl/dut_cmdq_pkg.sv
// Shared types for the tinyALU command queue: command payload, issue FSM states, error codes.
package dut_cmdq_pkg;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [7:0]  op;
        logic        op_pf;
        logic        sv;
    } cmdq_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } cmdq_state_e;

    localparam logic [7:0] CMDQ_ERR_TIMEOUT = 8'hFE;

endpackage

// File: rtl/dut_cmdq_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit to tell full from empty.
module dut_cmdq_fifo
    import dut_cmdq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  cmdq_cmd_t                din,
    output cmdq_cmd_t                dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    cmdq_cmd_t     mem_r [DEPTH];
    logic [PW:0]   wr_ptr_r;
    logic [PW:0]   rd_ptr_r;

    assign dout  = mem_r[rd_ptr_r[PW-1:0]];
    assign full  = (wr_ptr_r[PW] != rd_ptr_r[PW]) && (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);
    assign empty = (wr_ptr_r == rd_ptr_r);
    assign count = wr_ptr_r - rd_ptr_r;

    // Storage write and pointer advance; a push while full is dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push && !full) begin
                mem_r[wr_ptr_r[PW-1:0]] <= din;
                wr_ptr_r                <= wr_ptr_r + (PW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr_r <= rd_ptr_r + (PW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/dut_cmd_queue.sv
// Command issue stage in front of the tinyALU: buffers host commands and runs them one at a time.
// Optional WAIT watchdog is compiled in with `DUT_CMDQ_TIMEOUT_EN.
module dut_cmd_queue
    import dut_cmdq_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [31:0]              cmd_A,
    input  logic [31:0]              cmd_B,
    input  logic [7:0]               cmd_op,
    input  logic                     cmd_op_pf,
    input  logic                     cmd_sv,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [63:0]              rsp_result,
    output logic [7:0]               rsp_err,
    output logic                     rsp_timeout,
    output logic [31:0]              dut_A,
    output logic [31:0]              dut_B,
    output logic [7:0]               dut_op,
    output logic                     dut_op_pf,
    output logic                     dut_sv,
    output logic                     dut_start,
    input  logic                     dut_done,
    input  logic [63:0]              dut_result,
    input  logic [7:0]               dut_err,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   q_count
);
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYC < 2) begin : g_bad_param
        $error("dut_cmd_queue: DEPTH must be a power of 2 >= 2 and TIMEOUT_CYC >= 2");
    end

    cmdq_state_e state_r;
    cmdq_cmd_t   fifo_din_s;
    cmdq_cmd_t   fifo_dout_s;
    cmdq_cmd_t   issue_r;
    logic        push_s;
    logic        pop_s;
    logic        full_s;
    logic        empty_s;
    logic        run_r;
    logic        start_r;
    logic        rsp_valid_r;
    logic [63:0] rsp_result_r;
    logic [7:0]  rsp_err_r;

`ifdef DUT_CMDQ_TIMEOUT_EN
    localparam int            TW      = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 2);
    logic [TW-1:0] wait_cnt_r;
    logic          rsp_timeout_r;
    assign rsp_timeout = rsp_timeout_r;
`else
    assign rsp_timeout = 1'b0;
`endif

    assign fifo_din_s = '{a: cmd_A, b: cmd_B, op: cmd_op, op_pf: cmd_op_pf, sv: cmd_sv};
    // run_r keeps cmd_ready low while reset is asserted.
    assign cmd_ready  = run_r && !full_s;
    assign push_s     = cmd_valid && cmd_ready;
    assign pop_s      = (state_r == ST_IDLE) && !empty_s;

    assign dut_A      = issue_r.a;
    assign dut_B      = issue_r.b;
    assign dut_op     = issue_r.op;
    assign dut_op_pf  = issue_r.op_pf;
    assign dut_sv     = issue_r.sv;
    assign dut_start  = start_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_result = rsp_result_r;
    assign rsp_err    = rsp_err_r;
    assign busy       = (state_r != ST_IDLE) || !empty_s;

    dut_cmdq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_s),
        .pop     (pop_s),
        .din     (fifo_din_s),
        .dout    (fifo_dout_s),
        .full    (full_s),
        .empty   (empty_s),
        .count   (q_count)
    );

    // Marks the first clock after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_r <= 1'b0;
        end else begin
            run_r <= 1'b1;
        end
    end

    // Issue FSM with issue register and response register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            issue_r      <= '0;
            start_r      <= 1'b0;
            rsp_valid_r  <= 1'b0;
            rsp_result_r <= 64'h0;
            rsp_err_r    <= 8'h00;
`ifdef DUT_CMDQ_TIMEOUT_EN
            wait_cnt_r    <= '0;
            rsp_timeout_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!empty_s) begin
                        issue_r <= fifo_dout_s;
                        start_r <= 1'b1;
                        state_r <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    start_r <= 1'b0;
                    state_r <= ST_WAIT;
`ifdef DUT_CMDQ_TIMEOUT_EN
                    wait_cnt_r <= '0;
`endif
                end
                ST_WAIT: begin
                    if (dut_done) begin
                        rsp_result_r <= dut_result;
                        rsp_err_r    <= dut_err;
                        rsp_valid_r  <= 1'b1;
                        state_r      <= ST_RESP;
`ifdef DUT_CMDQ_TIMEOUT_EN
                        rsp_timeout_r <= 1'b0;
                    end else if (wait_cnt_r == TO_LAST) begin
                        rsp_result_r  <= 64'h0;
                        rsp_err_r     <= CMDQ_ERR_TIMEOUT;
                        rsp_timeout_r <= 1'b1;
                        rsp_valid_r   <= 1'b1;
                        state_r       <= ST_RESP;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + TW'(1);
`endif
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    start_r     <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dut_cmd_queue.sv
// Directed bench for dut_cmd_queue with a transaction-level reference model and a stub tinyALU.
// Set DUT_CMDQ_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYC=8).
module tb_dut_cmd_queue;
    localparam int DEPTH = 4;
    localparam int TO    = 8;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [7:0]  op;
        logic        op_pf;
        logic        sv;
    } tcmd_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_A = 32'h0;
    logic [31:0] cmd_B = 32'h0;
    logic [7:0]  cmd_op = 8'h0;
    logic        cmd_op_pf = 1'b0;
    logic        cmd_sv = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_result;
    logic [7:0]  rsp_err;
    logic        rsp_timeout;
    logic [31:0] dut_A;
    logic [31:0] dut_B;
    logic [7:0]  dut_op;
    logic        dut_op_pf;
    logic        dut_sv;
    logic        dut_start;
    logic        dut_done = 1'b0;
    logic [63:0] dut_result = 64'h0;
    logic [7:0]  dut_err = 8'h0;
    logic        busy;
    logic [2:0]  q_count;

    int n_chk = 0;
    int n_fail = 0;

    dut_cmd_queue #(.DEPTH(DEPTH), .TIMEOUT_CYC(TO)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_A(cmd_A), .cmd_B(cmd_B),
        .cmd_op(cmd_op), .cmd_op_pf(cmd_op_pf), .cmd_sv(cmd_sv),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .dut_A(dut_A), .dut_B(dut_B), .dut_op(dut_op), .dut_op_pf(dut_op_pf), .dut_sv(dut_sv),
        .dut_start(dut_start), .dut_done(dut_done), .dut_result(dut_result), .dut_err(dut_err),
        .busy(busy), .q_count(q_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: wait bound expired (t=%0t)", nm, $time);
    endtask

    // Reference model: command list, one command in service, response register.
    tcmd_t       m_q[$];
    tcmd_t       m_cur = '0;
    int          m_ph = 0;  // 0 idle, 1 start cycle, 2 awaiting done, 3 response held
    logic [63:0] m_res = 64'h0;
    logic [7:0]  m_err = 8'h0;
    logic        m_to = 1'b0;
    logic        m_run = 1'b0;
    int          m_wc = 0;
    bit          m_acc;
    tcmd_t       m_in;

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_q.delete();
            m_cur = '0; m_ph = 0; m_res = 64'h0; m_err = 8'h0; m_to = 1'b0; m_run = 1'b0; m_wc = 0;
        end else begin
            m_acc = cmd_valid && m_run && (m_q.size() < DEPTH);
            m_in  = '{a: cmd_A, b: cmd_B, op: cmd_op, op_pf: cmd_op_pf, sv: cmd_sv};
            if (m_ph == 0) begin
                if (m_q.size() > 0) begin
                    m_cur = m_q.pop_front();
                    m_ph  = 1;
                end
            end else if (m_ph == 1) begin
                m_ph = 2;
                m_wc = 0;
            end else if (m_ph == 2) begin
                if (dut_done) begin
                    m_res = dut_result; m_err = dut_err; m_to = 1'b0; m_ph = 3;
                end
`ifdef DUT_CMDQ_TIMEOUT_EN
                else begin
                    m_wc++;
                    if (m_wc == TO - 1) begin
                        m_res = 64'h0; m_err = 8'hFE; m_to = 1'b1; m_ph = 3;
                    end
                end
`endif
            end else if (rsp_ready) begin
                m_ph = 0;
            end
            if (m_acc) m_q.push_back(m_in);
            m_run = 1'b1;
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    initial forever begin
        @(negedge clk);
        chk("q_count",   128'(q_count),   128'(m_q.size()));
        chk("cmd_ready", 128'(cmd_ready), 128'(m_run && (m_q.size() < DEPTH)));
        chk("busy",      128'(busy),      128'((m_ph != 0) || (m_q.size() != 0)));
        chk("dut_start", 128'(dut_start), 128'(m_ph == 1));
        chk("rsp_valid", 128'(rsp_valid), 128'(m_ph == 3));
        chk("dut_operands", 128'({dut_A, dut_B, dut_op, dut_op_pf, dut_sv}), 128'(m_cur));
        if (m_ph == 3) begin
            chk("rsp_result",  128'(rsp_result),  128'(m_res));
            chk("rsp_err",     128'(rsp_err),     128'(m_err));
            chk("rsp_timeout", 128'(rsp_timeout), 128'(m_to));
        end
    end

    // Stub tinyALU: result = A + B, err = 1 for opcode 8'h80, done dev_delay cycles after start.
    bit          dev_en = 1'b1;
    int          dev_delay = 1;
    bit          dev_armed = 1'b0;
    int          dev_left = 0;
    logic [63:0] dev_sum = 64'h0;
    logic [7:0]  dev_e = 8'h0;

    initial forever begin
        @(posedge clk); #2;
        dut_done = 1'b0;
        if (!reset_n) begin
            dev_armed = 1'b0;
        end else if (dev_armed) begin
            if (dev_left > 0) begin
                dev_left--;
            end else if (dev_en) begin
                dut_done = 1'b1; dut_result = dev_sum; dut_err = dev_e; dev_armed = 1'b0;
            end
        end else if (dut_start) begin
            dev_armed = 1'b1;
            dev_left  = dev_delay - 1;
            dev_sum   = 64'(dut_A) + 64'(dut_B);
            dev_e     = (dut_op == 8'h80) ? 8'h01 : 8'h00;
        end
    end

    // Accepted responses in the order they leave the DUT.
    logic [63:0] rsp_log[$];
    int          start_cnt = 0;
    initial forever begin
        @(negedge clk);
        if (rsp_valid && rsp_ready) rsp_log.push_back(rsp_result);
        if (dut_start) start_cnt++;
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic push_cmd(input logic [31:0] a, input logic [31:0] b, input logic [7:0] op);
        int n;
        n = 0;
        cmd_valid = 1'b1; cmd_A = a; cmd_B = b; cmd_op = op; cmd_op_pf = op[0]; cmd_sv = op[1];
        while (!cmd_ready && n < 200) begin tick(); n++; end
        if (n >= 200) bound_fail("push_wait");
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (!rsp_valid && n < 200) begin tick(); n++; end
        if (n >= 200) bound_fail("rsp_wait");
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || rsp_valid) && n < 400) begin tick(); n++; end
        if (n >= 400) bound_fail("idle_wait");
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        tick(); tick();
    endtask

    logic [63:0] held;
    int          cnt;
    int          s0;

    initial begin
        #2;
        tick();
        chk("reset_cmd_ready", 128'(cmd_ready), 128'(0));
        chk("reset_q_count",   128'(q_count),   128'(0));
        chk("reset_rsp_valid", 128'(rsp_valid), 128'(0));
        reset_n = 1'b1;
        tick(); tick();
        chk("post_reset_cmd_ready", 128'(cmd_ready), 128'(1));

        // Single command: start in N+2, done 3 cycles later, result 8.
        dev_en = 1'b1; dev_delay = 3; s0 = start_cnt;
        push_cmd(32'd5, 32'd3, 8'h01);
        chk("t1_no_start_n1", 128'(dut_start), 128'(0));
        tick();
        chk("t1_start_n2", 128'(dut_start), 128'(1));
        chk("t1_dut_A",    128'(dut_A),     128'(5));
        tick();
        chk("t1_start_one_cycle", 128'(dut_start), 128'(0));
        wait_rsp();
        chk("t1_rsp_result", 128'(rsp_result), 128'(64'h8));
        chk("t1_start_count", 128'(start_cnt - s0), 128'(1));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("t1_rsp_drop", 128'(rsp_valid), 128'(0));

        // Fill the FIFO while the device is stalled; responses come back in push order.
        dev_en = 1'b0; dev_delay = 1; rsp_log.delete();
        for (int i = 1; i <= 5; i++) push_cmd(32'(i * 16), 32'(i), 8'h02);
        chk("t2_full_count", 128'(q_count),   128'(4));
        chk("t2_full_ready", 128'(cmd_ready), 128'(0));
        cmd_valid = 1'b1; cmd_A = 32'd96; cmd_B = 32'd6; cmd_op = 8'h02;
        tick(); tick();
        chk("t2_held_off", 128'(q_count), 128'(4));
        dev_en = 1'b1; rsp_ready = 1'b1;
        push_cmd(32'd96, 32'd6, 8'h02);
        wait_idle();
        rsp_ready = 1'b0;
        chk("t2_rsp_n", 128'(rsp_log.size()), 128'(6));
`ifndef DUT_CMDQ_TIMEOUT_EN
        for (int i = 0; i < 6 && i < rsp_log.size(); i++)
            chk("t2_rsp_order", 128'(rsp_log[i]), 128'((i + 1) * 17));
`endif

        // Response back-pressure: no second start while the first response waits.
        push_cmd(32'd100, 32'd1, 8'h03);
        push_cmd(32'd200, 32'd2, 8'h04);
        wait_rsp();
        held = rsp_result;
        s0 = start_cnt;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t3_rsp_stable", 128'(rsp_result), 128'(held));
        end
        chk("t3_first_rsp",   128'(held),             128'(101));
        chk("t3_no_new_start", 128'(start_cnt - s0),  128'(0));
        chk("t3_queued",      128'(q_count),          128'(1));
        rsp_ready = 1'b1;
        wait_idle();
        rsp_ready = 1'b0;

        // Device error propagates.
        push_cmd(32'd7, 32'd7, 8'h80);
        wait_rsp();
        chk("t4_rsp_err",     128'(rsp_err),     128'(8'h01));
        chk("t4_rsp_timeout", 128'(rsp_timeout), 128'(0));
        chk("t4_rsp_result",  128'(rsp_result),  128'(14));
        rsp_ready = 1'b1;
        wait_idle();
        rsp_ready = 1'b0;

        // Reset while waiting on the device with three commands queued.
        dev_en = 1'b0;
        for (int i = 0; i < 4; i++) push_cmd(32'(i), 32'd1, 8'h05);
        chk("t5_queued", 128'(q_count), 128'(3));
        reset_n = 1'b0;
        #1;
        chk("t5_rst_q_count",   128'(q_count),   128'(0));
        chk("t5_rst_busy",      128'(busy),      128'(0));
        chk("t5_rst_dut_A",     128'(dut_A),     128'(0));
        chk("t5_rst_cmd_ready", 128'(cmd_ready), 128'(0));
        chk("t5_rst_rsp_valid", 128'(rsp_valid), 128'(0));
        tick(); tick();
        reset_n = 1'b1; dev_en = 1'b1; rsp_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rsp_valid) cnt++;
        end
        chk("t5_no_rsp_after_reset", 128'(cnt), 128'(0));
        rsp_ready = 1'b0;

`ifdef DUT_CMDQ_TIMEOUT_EN
        // Watchdog: device never answers.
        dev_en = 1'b0;
        push_cmd(32'd9, 32'd9, 8'h06);
        cnt = 0;
        while (!dut_start && cnt < 50) begin tick(); cnt++; end
        if (cnt >= 50) bound_fail("t6_start_wait");
        cnt = 0;
        while (!rsp_valid && cnt < 50) begin tick(); cnt++; end
        chk("t6_latency",     128'(cnt),         128'(TO));
        chk("t6_err",         128'(rsp_err),     128'(8'hFE));
        chk("t6_timeout",     128'(rsp_timeout), 128'(1));
        chk("t6_result",      128'(rsp_result),  128'(0));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        do_reset();
`endif

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
